mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Two-requester controller for the single-ported main data memory below the L2. It arbitrates L2 refill and writeback traffic from two clients (port 0: instruction-side L2, port 1: data-side L2) round-robin. It sequences each granted read as a BURST_LEN-beat aligned burst and each write as a single beat. It owns the memory's address, read and write strobes; clients never drive the memory directly.

## Interface
- ADDR_W, 32, word-address width
- DATA_W, 32, data width
- BURST_LEN, 8, beats per read burst; power of 2, ≥2; BW = log2(BURST_LEN)

- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- reqN_valid  in  1  request from port N (N=0,1); held until grant
- reqN_write  in  1  1 = single-word write, 0 = burst read
- reqN_addr  in  ADDR_W  word address
- reqN_wdata  in  DATA_W  write data
- reqN_grant  out  1  one-cycle pulse: request accepted, fields captured
- reqN_rvalid  out  1  read beat valid for port N
- reqN_done  out  1  one-cycle pulse: transaction complete
- rbeat  out  BW  beat index of current rvalid
- rdata  out  DATA_W  read data, qualified by reqN_rvalid
- busy  out  1  FSM not IDLE
- mem_addr  out  ADDR_W  memory word address
- mem_wdata  out  DATA_W  memory write data
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- mem_rdata  in  DATA_W  memory data; valid the cycle after mem_read

## Operation
- States: IDLE, READ, WRITE, DONE.
- IDLE: sample valids. If only one port is valid, select it. If both are valid, select the port other than last_served. last_served resets to 1, so port 0 wins the first tie.
- On selection: latch port id, write flag, address and wdata. Pulse reqN_grant. Go to READ or WRITE.
- READ: base = addr with low BW bits cleared; the beat counter runs 0..BURST_LEN-1. Each cycle drive mem_read=1 and mem_addr=base+beat. After the last beat go to DONE.
- Return path: registered copies of mem_read, the port and the beat drive reqN_rvalid and rbeat one cycle later. rdata = mem_rdata (pass-through).
- WRITE: one cycle with mem_write=1, mem_addr=addr (unaligned), mem_wdata=wdata. Then go to DONE.
- DONE: one cycle with reqN_done=1. Update last_served to the completed port. Return to IDLE.
- Both write and read strobes are never high in the same cycle.
- Valid on the non-selected port, or on the active port after grant, is ignored until IDLE. A new request from the active port is a fresh request.
- A client may drop valid before its grant with no effect.
- Address arithmetic stays within the aligned block; no carry out of the low BW bits.

## Timing
- Reset (asynchronous, any state): FSM goes to IDLE; every output 0 (grants, rvalids, dones, strobes, busy, mem_addr, mem_wdata, rbeat). An in-flight burst is abandoned with no done and no further rvalid. last_served resets to 1.
- Read, valid sampled in IDLE at cycle 0:
  - grant and mem_read (beat 0) in cycle 1.
  - mem_read beats 0..7 in cycles 1..8.
  - rvalid beats 0..7 in cycles 2..9.
  - done in cycle 9, coincident with rvalid beat 7.
  - IDLE in cycle 10.
- Write, valid sampled at cycle 0: grant and mem_write in cycle 1; done in cycle 2; IDLE in cycle 3.
- Back-to-back: the earliest next grant is the cycle after the IDLE cycle. A read therefore occupies 10 cycles (grant to IDLE inclusive) and a write 3.
- busy is high from the grant cycle through the DONE cycle.

## Test plan
- Single read: port 0 read, addr 0x13, memory preloaded data[i]=i -> grant0 in cycle 1; mem_addr 0x10..0x17; rvalid0 with rdata 0x10..0x17 and rbeat 0..7; done0 with beat 7.
- Single write: port 1 write, addr 0x05, wdata 0xDEAD -> one mem_write cycle at 0x05; done1 the next cycle; a following read of 0x00 returns 0xDEAD at beat 5.
- Tie after reset: both ports request reads -> port 0 granted first; port 1 granted the cycle after port 0's IDLE cycle. Both stay valid again -> port 0 next, strictly alternating.
- Continuous port 0 with intermittent port 1: port 1 is never starved; it is granted at the first IDLE after asserting valid.
- Reset mid-burst: assert rst during beat 3 -> all outputs 0 immediately; no done; port 0 wins the next tie.
- Withdrawal: port 1 drops valid while port 0 is busy -> no grant1, no memory access for port 1.

Source files
------------

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_port_arbiter
//  Purpose  : Round-robin arbiter between the instruction-side and data-side
//             L2 for the single-ported main memory. Reads are issued as
//             aligned BURST_LEN-beat bursts, writes as one beat.
//  Revision : 1.0  initial release
// ============================================================================
module mem_port_arbiter #(
    parameter  int ADDR_W    = 32,
    parameter  int DATA_W    = 32,
    parameter  int BURST_LEN = 8,
    localparam int BW        = $clog2(BURST_LEN)
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              req0_valid,
    input  logic              req0_write,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              req0_grant,
    output logic              req0_rvalid,
    output logic              req0_done,

    input  logic              req1_valid,
    input  logic              req1_write,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              req1_grant,
    output logic              req1_rvalid,
    output logic              req1_done,

    output logic [BW-1:0]     rbeat,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,

    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [BW-1:0] c_last_beat = BW'(BURST_LEN - 1);
    localparam logic [BW-1:0] c_beat_one  = BW'(1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_port;
    logic              r_last_served;
    logic              r_grant;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [BW-1:0]     r_beat;
    logic              r_rvalid;
    logic              r_rport;
    logic [BW-1:0]     r_rbeat;

    logic              w_sel_valid;
    logic              w_sel_port;
    logic              w_sel_write;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_wdata;
    logic              w_start;

    // Pick a requester: a lone valid wins, a tie goes to the port not served last.
    always_comb begin
        w_sel_valid = req0_valid | req1_valid;
        if (req0_valid && req1_valid) begin
            w_sel_port = ~r_last_served;
        end else begin
            w_sel_port = req1_valid;
        end
        w_sel_write = w_sel_port ? req1_write : req0_write;
        w_sel_addr  = w_sel_port ? req1_addr  : req0_addr;
        w_sel_wdata = w_sel_port ? req1_wdata : req0_wdata;
        w_start     = (r_state == ST_IDLE) && w_sel_valid;
    end

    // Next-state decode; a read leaves READ after its last beat.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_sel_valid) w_state_nxt = w_sel_write ? ST_WRITE : ST_READ;
            ST_READ:  if (r_beat == c_last_beat) w_state_nxt = ST_DONE;
            ST_WRITE: w_state_nxt = ST_DONE;
            ST_DONE:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // State register, request capture, beat counter and round-robin history.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_port        <= 1'b0;
            r_last_served <= 1'b1;
            r_grant       <= 1'b0;
            r_addr        <= '0;
            r_wdata       <= '0;
            r_beat        <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_start;
            if (w_start) begin
                r_port  <= w_sel_port;
                r_addr  <= w_sel_addr;
                r_wdata <= w_sel_wdata;
            end
            // Counter wraps to zero after the last beat, ready for the next burst.
            if (r_state == ST_READ) begin
                r_beat <= r_beat + c_beat_one;
            end else begin
                r_beat <= '0;
            end
            if (r_state == ST_DONE) begin
                r_last_served <= r_port;
            end
        end
    end

    // Return path: memory data lands one cycle after the strobe, so delay the tags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rvalid <= 1'b0;
            r_rport  <= 1'b0;
            r_rbeat  <= '0;
        end else begin
            r_rvalid <= (r_state == ST_READ);
            r_rport  <= r_port;
            r_rbeat  <= (r_state == ST_READ) ? r_beat : '0;
        end
    end

    // Memory strobes and address; burst beats replace the low bits so no carry escapes the block.
    always_comb begin
        mem_read  = (r_state == ST_READ);
        mem_write = (r_state == ST_WRITE);
        mem_addr  = '0;
        mem_wdata = '0;
        if (mem_read) begin
            mem_addr = {r_addr[ADDR_W-1:BW], r_beat};
        end else if (mem_write) begin
            mem_addr  = r_addr;
            mem_wdata = r_wdata;
        end
    end

    assign busy        = (r_state != ST_IDLE);
    assign req0_grant  = r_grant & ~r_port;
    assign req1_grant  = r_grant &  r_port;
    assign req0_done   = (r_state == ST_DONE) & ~r_port;
    assign req1_done   = (r_state == ST_DONE) &  r_port;
    assign req0_rvalid = r_rvalid & ~r_rport;
    assign req1_rvalid = r_rvalid &  r_rport;
    assign rbeat       = r_rbeat;
    assign rdata       = mem_rdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_port_arbiter
//  Purpose  : Randomized self-checking bench. A transaction-level model
//             schedules the expected per-cycle outputs of every accepted
//             request from the timing rules and a shadow memory.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem_port_arbiter;

    localparam int ADDR_W    = 32;
    localparam int DATA_W    = 32;
    localparam int BURST_LEN = 8;
    localparam int BW        = 3;
    localparam int RING      = 32;

    // Bit positions in the packed control vector
    localparam int B_BUSY = 2;
    localparam int B_MR   = 1;
    localparam int B_MW   = 0;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [1:0]        vld = 2'b00;
    logic [1:0]        wr  = 2'b00;
    logic [ADDR_W-1:0] in_addr  [2];
    logic [DATA_W-1:0] in_wdata [2];

    logic              req0_grant, req0_rvalid, req0_done;
    logic              req1_grant, req1_rvalid, req1_done;
    logic [BW-1:0]     rbeat;
    logic [DATA_W-1:0] rdata;
    logic              busy;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_read, mem_write;
    logic [DATA_W-1:0] mem_rdata;

    logic [DATA_W-1:0] env_mem [256];
    logic [DATA_W-1:0] ref_mem [256];

    logic [8:0]        e_ctrl  [RING];
    logic [ADDR_W-1:0] e_addr  [RING];
    logic [DATA_W-1:0] e_wdata [RING];
    logic [DATA_W-1:0] e_rdata [RING];
    logic [BW-1:0]     e_rbeat [RING];

    int   cyc = 0;
    int   next_free = 0;
    int   rd_start = -100;
    int   rd_end = -100;
    logic last_served = 1'b1;
    logic [1:0] drop_next = 2'b00;
    bit   rand_en = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .BURST_LEN (BURST_LEN)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .req0_valid  (vld[0]),
        .req0_write  (wr[0]),
        .req0_addr   (in_addr[0]),
        .req0_wdata  (in_wdata[0]),
        .req0_grant  (req0_grant),
        .req0_rvalid (req0_rvalid),
        .req0_done   (req0_done),
        .req1_valid  (vld[1]),
        .req1_write  (wr[1]),
        .req1_addr   (in_addr[1]),
        .req1_wdata  (in_wdata[1]),
        .req1_grant  (req1_grant),
        .req1_rvalid (req1_rvalid),
        .req1_done   (req1_done),
        .rbeat       (rbeat),
        .rdata       (rdata),
        .busy        (busy),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .mem_rdata   (mem_rdata)
    );

    // Single-ported memory: read data appears the cycle after the strobe.
    always @(posedge clk) begin
        if (mem_read)  mem_rdata <= env_mem[mem_addr[7:0]];
        if (mem_write) env_mem[mem_addr[7:0]] <= mem_wdata;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic clear_ring();
        for (int i = 0; i < RING; i++) begin
            e_ctrl[i]  = '0;
            e_addr[i]  = '0;
            e_wdata[i] = '0;
            e_rdata[i] = '0;
            e_rbeat[i] = '0;
        end
    endtask

    task automatic check_cycle();
        int         s;
        logic [8:0] got;
        s   = cyc % RING;
        got = {req0_grant, req1_grant, req0_rvalid, req1_rvalid,
               req0_done, req1_done, busy, mem_read, mem_write};
        check_eq("ctrl", 64'(got), 64'(e_ctrl[s]));
        if (e_ctrl[s][B_MR] || e_ctrl[s][B_MW])
            check_eq("mem_addr", 64'(mem_addr), 64'(e_addr[s]));
        if (e_ctrl[s][B_MW])
            check_eq("mem_wdata", 64'(mem_wdata), 64'(e_wdata[s]));
        if (e_ctrl[s][6] || e_ctrl[s][5]) begin
            check_eq("rbeat", 64'(rbeat), 64'(e_rbeat[s]));
            check_eq("rdata", 64'(rdata), 64'(e_rdata[s]));
        end
        e_ctrl[s]  = '0;
        e_addr[s]  = '0;
        e_wdata[s] = '0;
        e_rdata[s] = '0;
        e_rbeat[s] = '0;
    endtask

    task automatic gen_inputs();
        for (int p = 0; p < 2; p++) begin
            if (drop_next[p]) begin
                vld[p]       = 1'b0;
                drop_next[p] = 1'b0;
            end
            if (!vld[p]) begin
                if (rand_en && $urandom_range(2) == 0) begin
                    vld[p]      = 1'b1;
                    wr[p]       = ($urandom_range(3) == 0);
                    in_addr[p]  = ADDR_W'($urandom_range(255));
                    in_wdata[p] = $urandom;
                end
            end else if (rand_en && $urandom_range(15) == 0) begin
                vld[p] = 1'b0;
            end
        end
    endtask

    // Transaction-level model: arbitrate when free, then lay out the whole
    // transaction's expected outputs on future cycles.
    task automatic model_select();
        int p, s, a, base;
        if (cyc >= next_free && vld != 2'b00) begin
            if (vld == 2'b11) p = last_served ? 0 : 1;
            else              p = vld[1] ? 1 : 0;
            last_served  = p[0];
            drop_next[p] = 1'b1;
            a = int'(in_addr[p]);
            if (wr[p]) begin
                s = (cyc + 1) % RING;
                e_ctrl[s][8-p]    = 1'b1;
                e_ctrl[s][B_BUSY] = 1'b1;
                e_ctrl[s][B_MW]   = 1'b1;
                e_addr[s]  = in_addr[p];
                e_wdata[s] = in_wdata[p];
                s = (cyc + 2) % RING;
                e_ctrl[s][4-p]    = 1'b1;
                e_ctrl[s][B_BUSY] = 1'b1;
                ref_mem[a & 255] = in_wdata[p];
                next_free = cyc + 3;
            end else begin
                base = a & ~(BURST_LEN - 1);
                for (int b = 0; b < BURST_LEN; b++) begin
                    s = (cyc + 1 + b) % RING;
                    e_ctrl[s][B_BUSY] = 1'b1;
                    e_ctrl[s][B_MR]   = 1'b1;
                    if (b == 0) e_ctrl[s][8-p] = 1'b1;
                    e_addr[s] = ADDR_W'(base + b);
                    s = (cyc + 2 + b) % RING;
                    e_ctrl[s][6-p] = 1'b1;
                    e_rbeat[s] = BW'(b);
                    e_rdata[s] = ref_mem[(base + b) & 255];
                end
                s = (cyc + BURST_LEN + 1) % RING;
                e_ctrl[s][4-p]    = 1'b1;
                e_ctrl[s][B_BUSY] = 1'b1;
                rd_start  = cyc + 1;
                rd_end    = cyc + BURST_LEN + 1;
                next_free = cyc + BURST_LEN + 2;
            end
        end
    endtask

    task automatic step();
        check_cycle();
        gen_inputs();
        model_select();
        @(negedge clk);
        cyc++;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        vld       = 2'b00;
        drop_next = 2'b00;
        #1;
        check_eq("reset_ctrl", 64'({req0_grant, req1_grant, req0_rvalid, req1_rvalid,
                 req0_done, req1_done, busy, mem_read, mem_write, rbeat}), 64'd0);
        check_eq("reset_mem", {mem_addr, mem_wdata}, 64'd0);
        @(negedge clk);
        cyc++;
        rst = 1'b0;
        clear_ring();
        last_served = 1'b1;
        next_free   = cyc;
        rd_start    = -100;
        rd_end      = -100;
    endtask

    task automatic issue(input int p, input logic w, input int a, input logic [DATA_W-1:0] d);
        vld[p]      = 1'b1;
        wr[p]       = w;
        in_addr[p]  = ADDR_W'(a);
        in_wdata[p] = d;
    endtask

    task automatic run_until_idle();
        for (int i = 0; i < 60; i++) begin
            step();
            if (vld == 2'b00 && drop_next == 2'b00 && cyc >= next_free) break;
        end
    endtask

    initial begin
        in_addr[0]  = '0;
        in_addr[1]  = '0;
        in_wdata[0] = '0;
        in_wdata[1] = '0;
        for (int i = 0; i < 256; i++) begin
            env_mem[i] = DATA_W'(i);
            ref_mem[i] = DATA_W'(i);
        end
        clear_ring();
        @(negedge clk);
        do_reset();

        // Single aligned read burst from port 0
        issue(0, 1'b0, 'h13, '0);
        run_until_idle();
        // Single write from port 1, then read it back inside a burst
        issue(1, 1'b1, 'h05, 32'hDEAD);
        run_until_idle();
        issue(0, 1'b0, 'h00, '0);
        run_until_idle();

        // Ties after reset alternate starting with port 0
        do_reset();
        issue(0, 1'b0, 'h40, '0);
        issue(1, 1'b0, 'h80, '0);
        run_until_idle();
        issue(0, 1'b1, 'h21, 32'h1234_5678);
        issue(1, 1'b0, 'h20, '0);
        run_until_idle();

        // Random traffic with withdrawals and occasional mid-burst resets
        rand_en = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if (cyc > rd_start + 2 && cyc <= rd_end && $urandom_range(40) == 0)
                do_reset();
            step();
        end
        rand_en = 1'b0;
        run_until_idle();
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
